// File: rtl/reg_file_cmd_ctrl_if.sv
// rtl/reg_file_cmd_ctrl_if.sv - command, response and register-file pin bundle for reg_file_cmd_ctrl
interface reg_file_cmd_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              Cmd_Valid;
  logic              Cmd_Ready;
  logic              Cmd_Wr;
  logic [ADDR_W-1:0] Cmd_Addr;
  logic [ADDR_W-1:0] Cmd_Len;
  logic [DATA_W-1:0] Cmd_Data;
  logic              RF_WrEn;
  logic              RF_RdEn;
  logic [ADDR_W-1:0] RF_Address;
  logic [DATA_W-1:0] RF_WrData;
  logic [DATA_W-1:0] RF_RdData;
  logic              Rsp_Valid;
  logic              Rsp_Ready;
  logic [DATA_W-1:0] Rsp_Data;
  logic              Rsp_Last;
  logic              Busy;

  // master: the environment (command source, response sink, register file)
  modport master (
    output Cmd_Valid, Cmd_Wr, Cmd_Addr, Cmd_Len, Cmd_Data, Rsp_Ready, RF_RdData,
    input  Cmd_Ready, RF_WrEn, RF_RdEn, RF_Address, RF_WrData,
           Rsp_Valid, Rsp_Data, Rsp_Last, Busy
  );

  modport slave (
    input  Cmd_Valid, Cmd_Wr, Cmd_Addr, Cmd_Len, Cmd_Data, Rsp_Ready, RF_RdData,
    output Cmd_Ready, RF_WrEn, RF_RdEn, RF_Address, RF_WrData,
           Rsp_Valid, Rsp_Data, Rsp_Last, Busy
  );
endinterface

// File: rtl/reg_file_cmd_ctrl.sv
// rtl/reg_file_cmd_ctrl.sv - single-master sequencer turning write / burst-read commands into register-file pin activity
module reg_file_cmd_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input logic             CLK,
  input logic             RST,
  reg_file_cmd_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, CAPTURE, RESP} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_last_q, rsp_last_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.Cmd_Valid) state_d = bus.Cmd_Wr ? WRITE : READ;
      WRITE:   state_d = IDLE;
      READ:    state_d = CAPTURE;
      CAPTURE: state_d = RESP;
      RESP:    if (bus.Rsp_Ready) state_d = (rem_q == '0) ? IDLE : READ;
      default: state_d = IDLE;
    endcase
  end

  // Enables are pure state decodes, so read and write can never overlap.
  always_comb begin
    bus.Cmd_Ready = (state_q == IDLE);
    bus.Busy      = (state_q != IDLE);
    bus.RF_WrEn   = (state_q == WRITE);
    bus.RF_RdEn   = (state_q == READ);
  end

  always_comb begin
    addr_d      = addr_q;
    rem_d       = rem_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = rsp_last_q;
    case (state_q)
      IDLE: begin
        if (bus.Cmd_Valid) begin
          addr_d = bus.Cmd_Addr;
          rem_d  = bus.Cmd_Len;
          if (bus.Cmd_Wr) wdata_d = bus.Cmd_Data;
        end
      end
      CAPTURE: begin
        rsp_data_d  = bus.RF_RdData;
        rsp_last_d  = (rem_q == '0);
        rsp_valid_d = 1'b1;
      end
      RESP: begin
        if (bus.Rsp_Ready) begin
          rsp_valid_d = 1'b0;
          if (rem_q != '0) begin
            addr_d = addr_q + 1'b1;
            rem_d  = rem_q - 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_q      <= '0;
      rem_q       <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  // addr_q only moves at accept or between beats, so the address pins hold their last value.
  assign bus.RF_Address = addr_q;
  assign bus.RF_WrData  = wdata_q;
  assign bus.Rsp_Valid  = rsp_valid_q;
  assign bus.Rsp_Data   = rsp_data_q;
  assign bus.Rsp_Last   = rsp_last_q;

endmodule

// File: tb/tb_reg_file_cmd_ctrl.sv
// tb/tb_reg_file_cmd_ctrl.sv - directed table, corner sequences and random scoreboard for reg_file_cmd_ctrl
module tb_reg_file_cmd_ctrl;

  logic CLK;
  logic RST;

  reg_file_cmd_ctrl_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  reg_file_cmd_ctrl #(.DATA_W(16), .ADDR_W(3)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Register file: one-cycle read latency, untouched by reset.
  logic [15:0] rf_mem [8];
  logic [15:0] rf_rd_q;
  always @(posedge CLK) begin
    if (bus.RF_WrEn) rf_mem[bus.RF_Address] <= bus.RF_WrData;
    if (bus.RF_RdEn) rf_rd_q <= rf_mem[bus.RF_Address];
  end
  assign bus.RF_RdData = rf_rd_q;

  int checks = 0;
  int errors = 0;
  logic [15:0] mem_model [8];
  logic [16:0] exp_q [$];
  bit sb_en = 0;

  typedef struct {
    bit          wr;
    logic [2:0]  addr;
    logic [2:0]  len;
    logic [15:0] data;
    logic [15:0] exp_first;
    logic [15:0] exp_final;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout waiting for DUT", name);
  endtask

  task automatic send_cmd(input bit wr, input logic [2:0] a, input logic [2:0] l, input logic [15:0] d);
    int t = 0;
    @(negedge CLK);
    while (!bus.Cmd_Ready && t < 1000) begin
      @(negedge CLK);
      t++;
    end
    if (!bus.Cmd_Ready) begin
      timeout("cmd_ready");
      return;
    end
    bus.Cmd_Valid = 1'b1;
    bus.Cmd_Wr    = wr;
    bus.Cmd_Addr  = a;
    bus.Cmd_Len   = l;
    bus.Cmd_Data  = d;
    @(posedge CLK);
    if (wr) begin
      mem_model[a] = d;
    end else if (sb_en) begin
      for (int i = 0; i <= int'(l); i++)
        exp_q.push_back({(i == int'(l)), mem_model[3'(int'(a) + i)]});
    end
    #1 bus.Cmd_Valid = 1'b0;
  endtask

  task automatic recv_beat(input string name, input logic [15:0] d, input bit last, input bit check_data);
    int t = 0;
    @(negedge CLK);
    while (!bus.Rsp_Valid && t < 200) begin
      @(negedge CLK);
      t++;
    end
    if (!bus.Rsp_Valid) begin
      timeout(name);
      return;
    end
    if (check_data) chk({name, "_data"}, bus.Rsp_Data, d);
    chk({name, "_last"}, bus.Rsp_Last, last);
    bus.Rsp_Ready = 1'b1;
    @(posedge CLK);
    #1 bus.Rsp_Ready = 1'b0;
  endtask

  vec_t vecs [9];
  int conflicts = 0;
  bit drv_done = 0;

  initial begin
    vecs[0] = '{1'b1, 3'd1, 3'd0, 16'hBEEF, 16'h0000, 16'h0000};
    vecs[1] = '{1'b1, 3'd2, 3'd0, 16'h0F0F, 16'h0000, 16'h0000};
    vecs[2] = '{1'b0, 3'd1, 3'd1, 16'h0000, 16'hBEEF, 16'h0F0F};
    vecs[3] = '{1'b1, 3'd7, 3'd0, 16'h7777, 16'h0000, 16'h0000};
    vecs[4] = '{1'b0, 3'd7, 3'd2, 16'h0000, 16'h7777, 16'hBEEF};
    vecs[5] = '{1'b0, 3'd3, 3'd0, 16'h0000, 16'h0103, 16'h0103};
    vecs[6] = '{1'b1, 3'd3, 3'd0, 16'hFFFF, 16'h0000, 16'h0000};
    vecs[7] = '{1'b0, 3'd3, 3'd0, 16'h0000, 16'hFFFF, 16'hFFFF};
    vecs[8] = '{1'b0, 3'd0, 3'd7, 16'h0000, 16'h0100, 16'h7777};

    RST = 1'b1;
    bus.Cmd_Valid = 1'b0;
    bus.Cmd_Wr    = 1'b0;
    bus.Cmd_Addr  = '0;
    bus.Cmd_Len   = '0;
    bus.Cmd_Data  = '0;
    bus.Rsp_Ready = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("reset_cmd_ready", bus.Cmd_Ready, 1);
    chk("reset_outputs", {bus.RF_WrEn, bus.RF_RdEn, bus.RF_Address, bus.RF_WrData,
                          bus.Rsp_Valid, bus.Rsp_Data, bus.Rsp_Last, bus.Busy}, 0);

    // Single write: one-cycle enable pulse, back to IDLE the next cycle.
    send_cmd(1'b1, 3'd3, 3'd0, 16'hA5A5);
    @(negedge CLK);
    chk("wr_cycle0", {bus.RF_WrEn, bus.RF_RdEn, bus.RF_Address, bus.RF_WrData, bus.Cmd_Ready, bus.Busy},
        {1'b1, 1'b0, 3'd3, 16'hA5A5, 1'b0, 1'b1});
    @(negedge CLK);
    chk("wr_cycle1", {bus.RF_WrEn, bus.Cmd_Ready, bus.Busy}, {1'b0, 1'b1, 1'b0});

    // Write then single read: response two cycles after accept.
    send_cmd(1'b1, 3'd5, 3'd0, 16'h1234);
    send_cmd(1'b0, 3'd5, 3'd0, 16'h0000);
    @(negedge CLK);
    chk("rd_cycle0", {bus.RF_RdEn, bus.RF_WrEn, bus.RF_Address, bus.Rsp_Valid}, {1'b1, 1'b0, 3'd5, 1'b0});
    @(negedge CLK);
    chk("rd_cycle1", {bus.RF_RdEn, bus.Rsp_Valid}, {1'b0, 1'b0});
    @(negedge CLK);
    chk("rd_cycle2", {bus.Rsp_Valid, bus.Rsp_Data, bus.Rsp_Last}, {1'b1, 16'h1234, 1'b1});
    bus.Rsp_Ready = 1'b1;
    @(posedge CLK);
    #1 bus.Rsp_Ready = 1'b0;
    @(negedge CLK);
    chk("rd_done_ready", {bus.Cmd_Ready, bus.Rsp_Valid}, {1'b1, 1'b0});

    for (int n = 0; n < 8; n++) send_cmd(1'b1, 3'(n), 3'd0, 16'h0100 + 16'(n));

    // Wrapping burst.
    send_cmd(1'b0, 3'd6, 3'd3, 16'h0000);
    recv_beat("wrap_b0", 16'h0106, 1'b0, 1'b1);
    recv_beat("wrap_b1", 16'h0107, 1'b0, 1'b1);
    recv_beat("wrap_b2", 16'h0100, 1'b0, 1'b1);
    recv_beat("wrap_b3", 16'h0101, 1'b1, 1'b1);

    // Response stall: outputs frozen, no extra reads, no command acceptance.
    send_cmd(1'b0, 3'd0, 3'd1, 16'h0000);
    begin
      int t = 0;
      @(negedge CLK);
      while (!bus.Rsp_Valid && t < 20) begin
        @(negedge CLK);
        t++;
      end
      for (int c = 0; c < 10; c++) begin
        chk("stall_state", {bus.Rsp_Valid, bus.Rsp_Data, bus.Rsp_Last, bus.RF_RdEn, bus.Cmd_Ready},
            {1'b1, 16'h0100, 1'b0, 1'b0, 1'b0});
        @(negedge CLK);
      end
      bus.Rsp_Ready = 1'b1;
      @(posedge CLK);
      #1 bus.Rsp_Ready = 1'b0;
    end
    recv_beat("stall_b1", 16'h0101, 1'b1, 1'b1);

    // Reset during the second beat of an 8-beat burst.
    send_cmd(1'b0, 3'd0, 3'd7, 16'h0000);
    recv_beat("rst_b0", 16'h0100, 1'b0, 1'b1);
    @(negedge CLK);
    chk("rst_beat1_reading", bus.RF_RdEn, 1);
    RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst_mid_state", {bus.Rsp_Valid, bus.Cmd_Ready, bus.Busy}, {1'b0, 1'b1, 1'b0});
    begin
      int seen = 0;
      for (int c = 0; c < 8; c++) begin
        if (bus.RF_RdEn || bus.Rsp_Valid) seen++;
        @(negedge CLK);
      end
      chk("rst_no_more_beats", seen, 0);
    end
    send_cmd(1'b0, 3'd2, 3'd0, 16'h0000);
    recv_beat("rst_after_read", 16'h0102, 1'b1, 1'b1);

    for (int v = 0; v < 9; v++) begin
      send_cmd(vecs[v].wr, vecs[v].addr, vecs[v].len, vecs[v].data);
      if (!vecs[v].wr) begin
        for (int b = 0; b <= int'(vecs[v].len); b++) begin
          if (b == 0)
            recv_beat($sformatf("vec%0d_b%0d", v, b), vecs[v].exp_first, (b == int'(vecs[v].len)), 1'b1);
          else if (b == int'(vecs[v].len))
            recv_beat($sformatf("vec%0d_b%0d", v, b), vecs[v].exp_final, 1'b1, 1'b1);
          else
            recv_beat($sformatf("vec%0d_b%0d", v, b), 16'h0000, 1'b0, 1'b0);
        end
      end
    end

    // Random command stream against the scoreboard.
    sb_en = 1'b1;
    fork
      begin
        for (int k = 0; k < 2000; k++)
          send_cmd(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   16'($urandom));
        drv_done = 1'b1;
      end
      begin
        int cyc = 0;
        while (!(drv_done && exp_q.size() == 0) && cyc < 80000) begin
          @(negedge CLK);
          cyc++;
          if (bus.RF_WrEn && bus.RF_RdEn) conflicts++;
          bus.Rsp_Ready = 1'($urandom_range(0, 1));
          if (bus.Rsp_Valid && bus.Rsp_Ready) begin
            if (exp_q.size() == 0) begin
              chk("rand_unexpected_rsp", bus.Rsp_Valid, 0);
            end else begin
              chk("rand_rsp", {bus.Rsp_Last, bus.Rsp_Data}, exp_q.pop_front());
            end
          end
        end
        if (cyc >= 80000) timeout("rand_stream");
      end
    join
    @(posedge CLK);
    #1 bus.Rsp_Ready = 1'b0;
    chk("rand_no_conflict", conflicts, 0);
    chk("rand_queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
